shreg_univ: RTL and testbench
=============================

Name: shreg_univ

Overview:
- Parametrised universal shift register with an embedded serializer.
- Idle mode: per-cycle opcode executes hold, shift left/right, rotate left/right or parallel load on a WIDTH-bit register.
- Serial mode: a valid/ready handshake accepts a word, which is shifted out one bit per enabled cycle, then a done pulse is raised.
- Serves as the common shift/serialize primitive for serial links (SPI/UART-style transmitters) and for test patterns.

Parameters:
- WIDTH, 8: register width in bits; legal range is 2 and above.
- MSB_FIRST, 1: 1 means serial output from q[WIDTH-1] with shift toward MSB; 0 means output from q[0] with shift toward LSB.
- FILL, 1'b0: bit shifted into the vacated end during serial mode.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  shift enable (baud tick); gates opcode execution and serial shifting.
- clr  in  1  synchronous clear/abort.
- op  in  3  shreg_pkg::op_t opcode, used in IDLE only.
- sin_l  in  1  serial input entering at LSB (shift-left ops).
- sin_r  in  1  serial input entering at MSB (shift-right ops).
- load_value  in  WIDTH  parallel load data for OP_LOAD.
- in_data  in  WIDTH  word to serialize.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word.
- q  out  WIDTH  register contents.
- sout  out  1  serial output bit.
- sout_valid  out  1  sout carries a serialized bit.
- busy  out  1  serializer active.
- done  out  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (rst=1, asynchronous):
  - q=0, state=IDLE, cnt=0, done=0.
  - Hence in_ready=1, busy=0, sout_valid=0.
- Combinational outputs:
  - sout = MSB_FIRST ? q[WIDTH-1] : q[0], in every state.
  - in_ready = busy = (state==SHIFT) inverted/true respectively: in_ready = (state==IDLE), busy = (state==SHIFT).
  - sout_valid = busy.
- done is registered. It is 1 for exactly the cycle after the final shift, otherwise 0.
- States: IDLE, SHIFT. cnt has width $clog2(WIDTH+1).
- Per-edge priority:
  1. clr: q<=0, state<=IDLE, cnt<=0, done<=0. No done pulse; any pending in_valid is not accepted.
  2. IDLE and in_valid: accept regardless of en. q<=in_data, cnt<=WIDTH, state<=SHIFT. op is ignored.
  3. IDLE and en: execute op.
     - OP_HOLD: q unchanged.
     - OP_SHL: q<={q[WIDTH-2:0],sin_l}.
     - OP_SHR: q<={sin_r,q[WIDTH-1:1]}.
     - OP_ROTL: q<={q[WIDTH-2:0],q[WIDTH-1]}.
     - OP_ROTR: q<={q[0],q[WIDTH-1:1]}.
     - OP_LOAD: q<=load_value.
     - Undefined codes behave as OP_HOLD.
  4. IDLE and en=0: q held.
  5. SHIFT and en:
     - Shift toward the output end with FILL entering the other end; cnt<=cnt-1.
     - If cnt==1: state<=IDLE, done<=1.
  6. SHIFT and en=0: everything held.
- Latency with en tied high:
  - Word accepted at edge E0; bit k of the serial order is on sout during cycle k+1 (k=0..WIDTH-1).
  - The last shift happens at edge E(WIDTH). After it, done=1 and in_ready=1 in the same cycle.
  - A back-to-back word is accepted at E(WIDTH+1), giving one idle cycle of gap. No same-edge turnaround.
- After serialization q holds all FILL bits.
- During SHIFT, op, sin_l, sin_r and load_value are ignored. in_valid is held off by in_ready=0, and the source must keep in_data stable until the handshake.
- rst asserted mid-transfer aborts immediately to the reset values. Deasserting rst requires no extra cycles.

Decomposition:
- shreg_pkg holds:
  - typedef enum logic [2:0] op_t = {OP_HOLD=0, OP_SHL=1, OP_SHR=2, OP_ROTL=3, OP_ROTR=4, OP_LOAD=5}.
  - typedef enum logic {IDLE, SHIFT} state_t.
- The op next-value logic is an always_comb case inside shreg_univ.
- No sub-module; the block is single-level.

Test Plan:
- Reset/idle (WIDTH=8): pulse rst mid-cycle -> q=0x00, in_ready=1, busy=0, done=0 immediately. Then, with en=1, OP_LOAD 0x81 -> q=0x81; OP_ROTL -> 0x03; OP_ROTR twice -> 0xC0; OP_SHL with sin_l=1 -> 0x81; OP_SHR with sin_r=0 -> 0x40.
- Serialize MSB_FIRST=1, en=1, in_data=0xA5 -> sout sequence 1,0,1,0,0,1,0,1 in cycles 1..8; busy=1 for cycles 1..8; done=1 in cycle 9 only; q=0x00 at the end.
- MSB_FIRST=0, FILL=1, in_data=0xA5 -> sout sequence 1,0,1,0,0,1,0,1 (LSB first); q=0xFF after completion.
- en gating: en=1 only every 4th cycle during SHIFT -> each bit is held exactly 4 cycles; done follows the 8th tick; in_valid during busy is not accepted (in_ready=0).
- Abort: clr after the 3rd bit -> next cycle state IDLE, q=0, no done pulse. Then rst asserted mid-transfer -> the same reset values asynchronously.
- Back-to-back: in_valid held high with 0x3C then 0xC3 -> second accept one cycle after done; 16 bits emitted with a single one-cycle gap; WIDTH=16 rerun checks the 16-cycle transfer and the 5-bit cnt.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register / serializer.
// Opcodes drive the idle-mode register operation; state_t tracks serializer activity.
package shreg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_ROTL = 3'd3,
    OP_ROTR = 3'd4,
    OP_LOAD = 3'd5
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shreg_univ.sv
// Universal shift register with an embedded serializer: per-cycle opcodes in IDLE,
// a handshaked word shifted out one bit per enabled cycle in SHIFT, then a done pulse.
module shreg_univ
  import shreg_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  op_t              op,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] q_r, q_nx_s, op_q_s, ser_q_s;
  logic [CW-1:0]    cnt_r, cnt_nx_s;
  logic             done_r, done_nx_s;

  // One serializer step: move toward the output end, FILL enters the far end.
  function automatic logic [WIDTH-1:0] ser_step(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      ser_step = {v[WIDTH-2:0], FILL};
    end else begin
      ser_step = {FILL, v[WIDTH-1:1]};
    end
  endfunction

  // Idle-mode opcode result; codes outside the defined set hold.
  always_comb begin
    op_q_s = q_r;
    case (op)
      OP_HOLD: op_q_s = q_r;
      OP_SHL:  op_q_s = {q_r[WIDTH-2:0], sin_l};
      OP_SHR:  op_q_s = {sin_r, q_r[WIDTH-1:1]};
      OP_ROTL: op_q_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
      OP_ROTR: op_q_s = {q_r[0], q_r[WIDTH-1:1]};
      OP_LOAD: op_q_s = load_value;
      default: op_q_s = q_r;
    endcase
  end

  assign ser_q_s = ser_step(q_r);

  // Next-state selection: clr beats a handshake, which beats the opcode.
  always_comb begin
    state_nx_s = state_r;
    q_nx_s     = q_r;
    cnt_nx_s   = cnt_r;
    done_nx_s  = 1'b0;
    if (clr) begin
      state_nx_s = IDLE;
      q_nx_s     = '0;
      cnt_nx_s   = '0;
    end else if (state_r == IDLE) begin
      if (in_valid) begin
        q_nx_s     = in_data;
        cnt_nx_s   = CW'(WIDTH);
        state_nx_s = SHIFT;
      end else if (en) begin
        q_nx_s = op_q_s;
      end else begin
        q_nx_s = q_r;
      end
    end else begin
      if (en) begin
        q_nx_s   = ser_q_s;
        cnt_nx_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_nx_s = IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = SHIFT;
        end
      end else begin
        q_nx_s = q_r;
      end
    end
  end

  // State, data, count and done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      q_r     <= '0;
      cnt_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      q_r     <= q_nx_s;
      cnt_r   <= cnt_nx_s;
      done_r  <= done_nx_s;
    end
  end

  assign q          = q_r;
  assign done       = done_r;
  assign sout       = MSB_FIRST ? q_r[WIDTH-1] : q_r[0];
  assign in_ready   = (state_r == IDLE);
  assign busy       = (state_r == SHIFT);
  assign sout_valid = (state_r == SHIFT);

endmodule

// File: tb/tb_shreg_univ.sv
// Bench for shreg_univ: three configurations checked every cycle against an arithmetic
// model, plus directed vectors with hand-computed values.
module tb_shreg_univ;
  import shreg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, clr = 1'b0, sin_l = 1'b0, sin_r = 1'b0;
  op_t         op = OP_HOLD;
  logic [15:0] load_value = 16'h0000, in_data = 16'h0000, in_data_w = 16'h0000;
  logic        in_valid8 = 1'b0, in_valid_w = 1'b0;

  logic [7:0]  q0, q1;
  logic [15:0] q2;
  logic        rdy0, so0, sv0, bsy0, dn0;
  logic        rdy1, so1, sv1, bsy1, dn1;
  logic        rdy2, so2, sv2, bsy2, dn2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shreg_univ #(.WIDTH(8), .MSB_FIRST(1'b1), .FILL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .op(op), .sin_l(sin_l), .sin_r(sin_r),
    .load_value(load_value[7:0]), .in_data(in_data[7:0]), .in_valid(in_valid8),
    .in_ready(rdy0), .q(q0), .sout(so0), .sout_valid(sv0), .busy(bsy0), .done(dn0));

  shreg_univ #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .op(op), .sin_l(sin_l), .sin_r(sin_r),
    .load_value(load_value[7:0]), .in_data(in_data[7:0]), .in_valid(in_valid8),
    .in_ready(rdy1), .q(q1), .sout(so1), .sout_valid(sv1), .busy(bsy1), .done(dn1));

  shreg_univ #(.WIDTH(16), .MSB_FIRST(1'b1), .FILL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .op(op), .sin_l(sin_l), .sin_r(sin_r),
    .load_value(load_value), .in_data(in_data_w), .in_valid(in_valid_w),
    .in_ready(rdy2), .q(q2), .sout(so2), .sout_valid(sv2), .busy(bsy2), .done(dn2));

  // Model: q during a transfer is the word displaced by the number of bits already sent.
  typedef struct {
    logic [31:0] q;
    logic [31:0] word;
    bit          busy;
    int          sent;
    bit          done;
  } model_t;

  model_t m0, m1, m2;

  function automatic logic [31:0] mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.q = 32'd0; r.word = 32'd0; r.busy = 1'b0; r.sent = 0; r.done = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] serial_q(input logic [31:0] word, input int s, input int w,
                                           input bit msb, input bit fill);
    logic [31:0] mk;
    mk = mask(w);
    if (msb) return ((word << s) | (fill ? ((32'd1 << s) - 32'd1) : 32'd0)) & mk;
    else     return (word >> s) | (fill ? (mk & ~(mk >> s)) : 32'd0);
  endfunction

  function automatic model_t step(input model_t m, input int w, input bit msb, input bit fill,
                                  input logic valid, input logic [31:0] data,
                                  input logic [31:0] lv);
    model_t n;
    logic [31:0] mk;
    mk = mask(w);
    n = m;
    n.done = 1'b0;
    if (clr) begin
      n.q = 32'd0; n.busy = 1'b0; n.sent = 0;
    end else if (!m.busy) begin
      if (valid) begin
        n.word = data & mk; n.busy = 1'b1; n.sent = 0; n.q = n.word;
      end else if (en) begin
        case (int'(op))
          1: n.q = ((m.q << 1) | 32'(sin_l)) & mk;
          2: n.q = (m.q >> 1) | (32'(sin_r) << (w - 1));
          3: n.q = ((m.q << 1) | (m.q >> (w - 1))) & mk;
          4: n.q = (m.q >> 1) | ((m.q & 32'd1) << (w - 1));
          5: n.q = lv & mk;
          default: n.q = m.q;
        endcase
      end
    end else if (en) begin
      n.sent = m.sent + 1;
      n.q = serial_q(m.word, n.sent, w, msb, fill);
      if (n.sent == w) begin
        n.busy = 1'b0; n.done = 1'b1;
      end
    end
    return n;
  endfunction

  // Advance the three models on the same edges as the DUTs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= model_reset();
      m1 <= model_reset();
      m2 <= model_reset();
    end else begin
      m0 <= step(m0, 8, 1'b1, 1'b0, in_valid8, {16'd0, in_data}, {16'd0, load_value});
      m1 <= step(m1, 8, 1'b0, 1'b1, in_valid8, {16'd0, in_data}, {16'd0, load_value});
      m2 <= step(m2, 16, 1'b1, 1'b0, in_valid_w, {16'd0, in_data_w}, {16'd0, load_value});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input model_t m, input int w, input bit msb,
                     input logic [31:0] qa, input logic so, input logic rdy,
                     input logic bsy, input logic sv, input logic dn);
    chk({tag, ".q"}, qa, m.q);
    chk({tag, ".sout"}, {31'd0, so}, {31'd0, msb ? m.q[w-1] : m.q[0]});
    chk({tag, ".in_ready"}, {31'd0, rdy}, {31'd0, !m.busy});
    chk({tag, ".busy"}, {31'd0, bsy}, {31'd0, m.busy});
    chk({tag, ".sout_valid"}, {31'd0, sv}, {31'd0, m.busy});
    chk({tag, ".done"}, {31'd0, dn}, {31'd0, m.done});
  endtask

  // Every-cycle comparison against the models, away from the active edge.
  always @(negedge clk) begin
    cmp("w8msb", m0, 8, 1'b1, {24'd0, q0}, so0, rdy0, bsy0, sv0, dn0);
    cmp("w8lsb", m1, 8, 1'b0, {24'd0, q1}, so1, rdy1, bsy1, sv1, dn1);
    cmp("w16", m2, 16, 1'b1, {16'd0, q2}, so2, rdy2, bsy2, sv2, dn2);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset_pulse(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk({name, ".q"}, {24'd0, q0}, 32'h00);
    chk({name, ".in_ready"}, {31'd0, rdy0}, 32'd1);
    chk({name, ".busy"}, {31'd0, bsy0}, 32'd0);
    chk({name, ".done"}, {31'd0, dn0}, 32'd0);
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0]  s0, s1, w96;
    logic [15:0] bb;
    int          nb, gaps;

    repeat (2) tick();
    rst = 1'b0;
    tick();
    en = 1'b1; op = OP_LOAD; load_value = 16'h125A;
    tick();
    chk("pre_reset_load", {24'd0, q0}, 32'h5A);
    en = 1'b0;
    async_reset_pulse("reset");

    // Idle opcodes.
    en = 1'b1; op = OP_LOAD; load_value = 16'h0081;
    tick(); chk("op_load", {24'd0, q0}, 32'h81);
    op = OP_ROTL; tick(); chk("op_rotl", {24'd0, q0}, 32'h03);
    op = OP_ROTR; tick(); chk("op_rotr1", {24'd0, q0}, 32'h81);
    tick(); chk("op_rotr2", {24'd0, q0}, 32'hC0);
    op = OP_SHL; sin_l = 1'b1; tick(); chk("op_shl", {24'd0, q0}, 32'h81);
    op = OP_SHR; sin_r = 1'b0; tick(); chk("op_shr", {24'd0, q0}, 32'h40);
    op = op_t'(3'd7); tick(); chk("op_undef", {24'd0, q0}, 32'h40);
    op = OP_LOAD; load_value = 16'h00FF; en = 1'b0; tick(); chk("en_low_hold", {24'd0, q0}, 32'h40);

    // Serialize 0xA5 MSB-first (fill 0) and LSB-first (fill 1) side by side.
    op = OP_HOLD; en = 1'b1; in_data = 16'h00A5; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s0[7-k] = so0;
      s1[k]   = so1;
      chk("ser_busy", {31'd0, bsy0}, 32'd1);
      chk("ser_no_done", {31'd0, dn0}, 32'd0);
      tick();
    end
    chk("ser_msb_bits", {24'd0, s0}, 32'hA5);
    chk("ser_lsb_bits", {24'd0, s1}, 32'hA5);
    chk("ser_done", {31'd0, dn0}, 32'd1);
    chk("ser_ready_with_done", {31'd0, rdy0}, 32'd1);
    chk("ser_q_fill0", {24'd0, q0}, 32'h00);
    chk("ser_q_fill1", {24'd0, q1}, 32'hFF);
    tick();
    chk("ser_done_one_cycle", {31'd0, dn0}, 32'd0);

    // en gating: one tick every 4 cycles; in_valid stays high while busy.
    w96 = 8'h96;
    in_data = 16'h0096; in_valid8 = 1'b1; en = 1'b0;
    tick();
    in_data = 16'h0011;
    for (int c = 1; c <= 32; c++) begin
      chk("gate_bit", {31'd0, so0}, {31'd0, w96[7 - (c - 1) / 4]});
      chk("gate_not_ready", {31'd0, rdy0}, 32'd0);
      en = (c % 4 == 0);
      tick();
    end
    chk("gate_done", {31'd0, dn0}, 32'd1);
    in_valid8 = 1'b0; en = 1'b1;
    tick();

    // Abort with clr after the third bit, then async reset mid-transfer.
    in_data = 16'h00F0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    repeat (3) tick();
    chk("abort_q_before", {24'd0, q0}, 32'h80);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("abort_idle", {31'd0, bsy0}, 32'd0);
    chk("abort_q", {24'd0, q0}, 32'h00);
    chk("abort_no_done", {31'd0, dn0}, 32'd0);
    tick();
    chk("abort_no_done_late", {31'd0, dn0}, 32'd0);
    in_data = 16'h003C; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    async_reset_pulse("midreset");

    // Back-to-back words with in_valid held high.
    in_data = 16'h003C; in_valid8 = 1'b1;
    tick();
    in_data = 16'h00C3;
    bb = 16'h0000; nb = 0; gaps = 0;
    for (int c = 1; c <= 17; c++) begin
      if (bsy0) begin
        bb = {bb[14:0], so0};
        nb++;
      end else begin
        gaps++;
      end
      if (c == 10) in_valid8 = 1'b0;
      tick();
    end
    chk("b2b_bits", {16'd0, bb}, 32'h3CC3);
    chk("b2b_count", nb, 32'd16);
    chk("b2b_gap", gaps, 32'd1);
    chk("b2b_done", {31'd0, dn0}, 32'd1);
    tick();

    // WIDTH=16 transfer.
    in_data_w = 16'hBEEF; in_valid_w = 1'b1;
    tick();
    in_valid_w = 1'b0;
    bb = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      chk("w16_busy", {31'd0, bsy2}, 32'd1);
      bb = {bb[14:0], so2};
      tick();
    end
    chk("w16_bits", {16'd0, bb}, 32'hBEEF);
    chk("w16_done", {31'd0, dn2}, 32'd1);
    chk("w16_q", {16'd0, q2}, 32'h0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
